// File: rtl/var_accum_pkg.sv
// Shared defaults, derived widths and FSM encoding for the block variance accumulator.
package norm_pkg;

  localparam int DW_DEF    = 8;
  localparam int LOG2N_DEF = 4;
  localparam int SUM_W     = DW_DEF + LOG2N_DEF;
  localparam int SQ_W      = 2 * DW_DEF + LOG2N_DEF;
  localparam int PROD_W    = 2 * SUM_W;
  localparam int VAR_W     = 16;

  typedef enum logic [1:0] {
    ACC  = 2'd0,
    SQ   = 2'd1,
    CALC = 2'd2,
    OUT  = 2'd3
  } state_t;

endpackage

// File: rtl/var_accum_if.sv
// Sample-in / result-out handshake bundle; the accumulator sits on the slave side.
interface var_accum_if
  import norm_pkg::*;
#(
  parameter int DW = DW_DEF
);

  logic             in_valid;
  logic [DW-1:0]    in_data;
  logic             in_ready;
  logic             var_valid;
  logic             var_ready;
  logic [VAR_W-1:0] var_out;
  logic [DW-1:0]    mean_out;

  modport master (
    output in_valid, in_data, var_ready,
    input  in_ready, var_valid, var_out, mean_out
  );

  modport slave (
    input  in_valid, in_data, var_ready,
    output in_ready, var_valid, var_out, mean_out
  );

endinterface

// File: rtl/var_accum_seq_mult.sv
// Shift-add multiplier: the start edge performs the first partial product,
// then W-1 more edges follow; done is high for the cycle after the last step.
module seq_mult #(
  parameter int W = 12
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   op_a,
  input  logic [W-1:0]   op_b,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int CW = $clog2(W + 1);

  logic [2*W-1:0] mcand_r;
  logic [2*W-1:0] acc_r;
  logic [W-1:0]   mplier_r;
  logic [CW-1:0]  step_r;
  logic           busy_r;
  logic           done_r;
  logic [2*W-1:0] a_ext_s;

  assign a_ext_s = {{W{1'b0}}, op_a};
  assign done    = done_r;
  assign product = acc_r;

  // load-and-first-step on start, then one partial product per cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_r  <= '0;
      acc_r    <= '0;
      mplier_r <= '0;
      step_r   <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else if (start) begin
      acc_r    <= op_b[0] ? a_ext_s : '0;
      mcand_r  <= a_ext_s << 1;
      mplier_r <= op_b >> 1;
      step_r   <= CW'(1);
      busy_r   <= 1'b1;
      done_r   <= 1'b0;
    end else if (busy_r) begin
      if (mplier_r[0]) begin
        acc_r <= acc_r + mcand_r;
      end
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      step_r   <= step_r + CW'(1);
      if (step_r == CW'(W - 1)) begin
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end
    end else begin
      done_r <= 1'b0;
    end
  end

endmodule

// File: rtl/var_accum.sv
// Accumulates blocks of 2^LOG2N unsigned samples and reports the population
// variance and mean of each block through a valid/ready result handshake.
module var_accum
  import norm_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int LOG2N = LOG2N_DEF
) (
  input logic        clk,
  input logic        reset,
  var_accum_if.slave bus
);

  localparam int SW = DW + LOG2N;
  localparam int QW = 2 * DW + LOG2N;
  localparam int PW = 2 * SW;

  state_t           state_r;
  logic [SW-1:0]    sum_r;
  logic [QW-1:0]    sumsq_r;
  logic [LOG2N-1:0] cnt_r;
  logic             in_ready_r;
  logic             var_valid_r;
  logic [VAR_W-1:0] var_out_r;
  logic [DW-1:0]    mean_out_r;

  logic             accept_s;
  logic             last_s;
  logic             mult_start_s;
  logic             mult_done_s;
  logic [2*DW-1:0]  x_sq_s;
  logic [SW-1:0]    sum_next_s;
  logic [QW-1:0]    sumsq_next_s;
  logic [PW-1:0]    sum_sq_s;
  logic [PW-1:0]    diff_s;
  logic [VAR_W-1:0] var_calc_s;
  logic [DW-1:0]    mean_calc_s;

  // next accumulator values and the CALC arithmetic
  always_comb begin
    accept_s     = in_ready_r && bus.in_valid;
    last_s       = (cnt_r == {LOG2N{1'b1}});
    mult_start_s = accept_s && last_s;
    x_sq_s       = bus.in_data * bus.in_data;
    sum_next_s   = sum_r + SW'(bus.in_data);
    sumsq_next_s = sumsq_r + QW'(x_sq_s);
    // N*sumsq >= sum^2 always holds, so the subtraction cannot wrap
    diff_s       = (PW'(sumsq_r) << LOG2N) - sum_sq_s;
    var_calc_s   = VAR_W'(diff_s >> (2 * LOG2N));
    mean_calc_s  = sum_r[SW-1:LOG2N];
  end

  // the squarer is fed the final sum on the same edge that accepts the last sample
  seq_mult #(
    .W (SW)
  ) u_sq (
    .clk     (clk),
    .reset   (reset),
    .start   (mult_start_s),
    .op_a    (sum_next_s),
    .op_b    (sum_next_s),
    .done    (mult_done_s),
    .product (sum_sq_s)
  );

  // block FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ACC;
      sum_r       <= '0;
      sumsq_r     <= '0;
      cnt_r       <= '0;
      in_ready_r  <= 1'b1;
      var_valid_r <= 1'b0;
      var_out_r   <= '0;
      mean_out_r  <= '0;
    end else begin
      case (state_r)
        ACC: begin
          if (accept_s) begin
            sum_r   <= sum_next_s;
            sumsq_r <= sumsq_next_s;
            cnt_r   <= cnt_r + {{(LOG2N-1){1'b0}}, 1'b1};
            if (last_s) begin
              state_r    <= SQ;
              in_ready_r <= 1'b0;
            end
          end
        end
        SQ: begin
          if (mult_done_s) begin
            state_r <= CALC;
          end
        end
        CALC: begin
          var_out_r   <= var_calc_s;
          mean_out_r  <= mean_calc_s;
          var_valid_r <= 1'b1;
          state_r     <= OUT;
        end
        OUT: begin
          if (bus.var_ready) begin
            var_valid_r <= 1'b0;
            sum_r       <= '0;
            sumsq_r     <= '0;
            cnt_r       <= '0;
            in_ready_r  <= 1'b1;
            state_r     <= ACC;
          end
        end
        default: begin
          state_r     <= ACC;
          in_ready_r  <= 1'b1;
          var_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.var_valid = var_valid_r;
  assign bus.var_out   = var_out_r;
  assign bus.mean_out  = mean_out_r;

endmodule

// File: tb/tb_var_accum.sv
// Directed table vectors, hold/reset sequences and randomized blocks against a
// straightforward sum/sum-of-squares model of the block variance.
module tb_var_accum;

  typedef struct packed {
    logic [15:0][7:0] s;
    logic [15:0]      var_exp;
    logic [7:0]       mean_exp;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  vec_t vecs [5];

  var_accum_if #(.DW(8)) bus ();

  var_accum #(
    .DW    (8),
    .LOG2N (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [23:0] model(input logic [15:0][7:0] s);
    int sum;
    int sumsq;
    int d;
    sum   = 0;
    sumsq = 0;
    for (int i = 0; i < 16; i++) begin
      sum   += int'(s[i]);
      sumsq += int'(s[i]) * int'(s[i]);
    end
    d = (16 * sumsq - sum * sum) / 256;
    return {d[15:0], 8'(sum / 16)};
  endfunction

  // offer one sample from a negedge until it is taken; returns at the next negedge
  task automatic push(input logic [7:0] x, input bit rnd);
    int guard;
    guard = 0;
    if (rnd) begin
      while ($urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = x;
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      chk("push_timeout", 32'(guard), 32'd0);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic run_block(input logic [15:0][7:0] s, input bit rnd,
                           input logic [15:0] ev, input logic [7:0] em,
                           input int hold, input string tag);
    int cyc;
    bit rdy_bad;
    bus.var_ready = (hold == 0);
    for (int i = 0; i < 16; i++) push(s[i], rnd);
    if (rnd) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hA5;
    end
    chk({tag, "_valid_early"}, 32'(bus.var_valid), 32'd0);
    cyc     = 0;
    rdy_bad = 1'b0;
    while (!bus.var_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.in_ready) rdy_bad = 1'b1;
    end
    bus.in_valid = 1'b0;
    chk({tag, "_latency"}, 32'(cyc), 32'd13);
    chk({tag, "_in_ready_busy"}, 32'(rdy_bad), 32'd0);
    chk({tag, "_var"}, 32'(bus.var_out), 32'(ev));
    chk({tag, "_mean"}, 32'(bus.mean_out), 32'(em));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk({tag, "_hold"}, {bus.var_valid, bus.in_ready, bus.mean_out, bus.var_out},
          {1'b1, 1'b0, em, ev});
    end
    bus.var_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_after_valid"}, 32'(bus.var_valid), 32'd0);
    chk({tag, "_after_in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_retain"}, {8'd0, bus.mean_out, bus.var_out}, {8'd0, em, ev});
    bus.var_ready = 1'b0;
  endtask

  initial begin
    logic [15:0][7:0] rs;
    logic [23:0]      exp_r;
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'd0;
    bus.var_ready = 1'b0;

    for (int j = 0; j < 16; j++) begin
      vecs[0].s[j] = 8'd100;
      vecs[1].s[j] = j[0] ? 8'd255 : 8'd0;
      vecs[2].s[j] = 8'(j);
      vecs[3].s[j] = 8'd255;
      vecs[4].s[j] = (j < 8) ? 8'd0 : 8'd16;
    end
    vecs[0].var_exp = 16'd0;     vecs[0].mean_exp = 8'd100;
    vecs[1].var_exp = 16'd16256; vecs[1].mean_exp = 8'd127;
    vecs[2].var_exp = 16'd21;    vecs[2].mean_exp = 8'd7;
    vecs[3].var_exp = 16'd0;     vecs[3].mean_exp = 8'd255;
    vecs[4].var_exp = 16'd64;    vecs[4].mean_exp = 8'd8;

    repeat (3) @(negedge clk);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_var_valid", 32'(bus.var_valid), 32'd0);
    chk("reset_var_out", 32'(bus.var_out), 32'd0);
    chk("reset_mean_out", 32'(bus.mean_out), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_in_ready", 32'(bus.in_ready), 32'd1);

    for (int v = 0; v < 5; v++) begin
      run_block(vecs[v].s, 1'b0, vecs[v].var_exp, vecs[v].mean_exp, 0, $sformatf("vec%0d", v));
    end

    // result held while downstream stalls
    run_block(vecs[1].s, 1'b0, 16'd16256, 8'd127, 5, "hold");

    // reset in the middle of a block drops the partial sums and the old result
    bus.var_ready = 1'b1;
    for (int i = 0; i < 7; i++) push(8'd33, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_var_valid", 32'(bus.var_valid), 32'd0);
    chk("midrst_var_out", 32'(bus.var_out), 32'd0);
    chk("midrst_mean_out", 32'(bus.mean_out), 32'd0);
    for (int j = 0; j < 16; j++) rs[j] = 8'd50;
    run_block(rs, 1'b0, 16'd0, 8'd50, 0, "midrst");

    // random blocks with gappy in_valid and junk offered while busy
    for (int b = 0; b < 1000; b++) begin
      for (int j = 0; j < 16; j++) rs[j] = 8'($urandom_range(0, 255));
      exp_r = model(rs);
      run_block(rs, 1'b1, exp_r[23:8], exp_r[7:0], int'($urandom_range(0, 2)),
                $sformatf("rnd%0d", b));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
